// File: rtl/db_req_gen.sv
// db_req_gen: accepts one parsed request, hashes its key with CRC-32 one byte
// per cycle, issues a single-cycle request pulse, then holds the outputs stable
// for a fixed window so the hash-table controller can keep sampling them.
module db_req_gen #(
    parameter int unsigned KEY_SIZE    = 96,
    parameter int unsigned HASH_SIZE   = 32,
    parameter int unsigned VAL_SIZE    = 32,
    parameter int unsigned HOLD_CYCLES = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [3:0]           s_op,
    input  logic [KEY_SIZE-1:0]  s_key,
    input  logic [VAL_SIZE-1:0]  s_value,
    output logic                 out_valid,
    output logic [3:0]           out_op,
    output logic [HASH_SIZE-1:0] out_hash,
    output logic [KEY_SIZE-1:0]  out_key,
    output logic [VAL_SIZE-1:0]  out_value,
    output logic                 busy,
    output logic [31:0]          req_cnt
);

    localparam int unsigned KEY_BYTES = KEY_SIZE / 8;
    localparam int unsigned IDX_W     = $clog2(KEY_BYTES + 1);
    localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

    typedef enum logic [1:0] {StIdle, StHash, StIssue, StHold} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [3:0]            r_op;
    logic [KEY_SIZE-1:0]   r_key;
    logic [VAL_SIZE-1:0]   r_value;
    logic [31:0]           r_crc;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [3:0]            r_out_op;
    logic [HASH_SIZE-1:0]  r_out_hash;
    logic [KEY_SIZE-1:0]   r_out_key;
    logic [VAL_SIZE-1:0]   r_out_value;
    logic [31:0]           r_req_cnt;

    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_hold_done;
    logic [KEY_SIZE-1:0]   w_key_shl;
    logic [7:0]            w_key_byte;
    logic [31:0]           w_crc_next;

    // Bytes are consumed MSB first: shift the current byte to the top of the key.
    assign w_key_shl   = r_key << {r_byte_idx, 3'b000};
    assign w_key_byte  = w_key_shl[KEY_SIZE-1 -: 8];
    assign w_accept    = s_valid & s_ready;
    assign w_last_byte = (r_byte_idx == IDX_W'(KEY_BYTES - 1));
    assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    // Ready is a pure state decode, forced low while reset is held.
    assign s_ready   = (r_state == StIdle) & ~rst;
    assign busy      = (r_state != StIdle);
    assign out_valid = (r_state == StIssue);
    assign out_op    = r_out_op;
    assign out_hash  = r_out_hash;
    assign out_key   = r_out_key;
    assign out_value = r_out_value;
    assign req_cnt   = r_req_cnt;

    // Fold one key byte into the running reflected CRC-32, LSB first.
    always_comb begin
        w_crc_next = r_crc ^ {24'h0, w_key_byte};
        for (int i = 0; i < 8; i++) begin
            w_crc_next = w_crc_next[0] ? ((w_crc_next >> 1) ^ CRC_POLY) : (w_crc_next >> 1);
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StHash;
            StHash:  if (w_last_byte) w_state_next = StIssue;
            StIssue: w_state_next = StHold;
            StHold:  if (w_hold_done) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Working registers: capture on accept, hash in HASH, count the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_key      <= '0;
            r_value    <= '0;
            r_crc      <= '0;
            r_byte_idx <= '0;
            r_hold_cnt <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op       <= s_op;
                        r_key      <= s_key;
                        r_value    <= s_value;
                        r_crc      <= 32'hFFFF_FFFF;
                        r_byte_idx <= '0;
                    end
                end
                StHash: begin
                    r_crc      <= w_crc_next;
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
                StIssue: r_hold_cnt <= '0;
                StHold:  r_hold_cnt <= r_hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Output registers change only on the edge entering ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_op    <= '0;
            r_out_hash  <= '0;
            r_out_key   <= '0;
            r_out_value <= '0;
            r_req_cnt   <= '0;
        end else if (r_state == StHash && w_last_byte) begin
            r_out_op    <= r_op;
            r_out_hash  <= HASH_SIZE'(w_crc_next ^ 32'hFFFF_FFFF);
            r_out_key   <= r_key;
            r_out_value <= r_value;
            r_req_cnt   <= r_req_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_db_req_gen.sv
// Self-checking bench for db_req_gen: table-driven directed requests, reset and
// counter-wrap sequences, then randomized requests against a table-based CRC-32 model.
module tb_db_req_gen;

    localparam int KB = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [3:0]   s_op;
    logic [95:0]  s_key;
    logic [31:0]  s_value;
    logic         out_valid;
    logic [3:0]   out_op;
    logic [31:0]  out_hash;
    logic [95:0]  out_key;
    logic [31:0]  out_value;
    logic         busy;
    logic [31:0]  req_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model state: last issued request and issue count.
    logic [3:0]   p_op;
    logic [95:0]  p_key;
    logic [31:0]  p_val;
    logic [31:0]  p_hash;
    logic [31:0]  m_cnt;
    logic [31:0]  crc_tbl [256];

    typedef struct {
        logic [3:0]  op;
        logic [95:0] key;
        logic [31:0] val;
        bit          scramble;
        bit          keep_valid;
        logic [31:0] exp_hash;
    } vec_t;

    vec_t vecs [6];
    int   acc  [6];

    db_req_gen #(
        .KEY_SIZE    (96),
        .HASH_SIZE   (32),
        .VAL_SIZE    (32),
        .HOLD_CYCLES (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_op      (s_op),
        .s_key     (s_key),
        .s_value   (s_value),
        .out_valid (out_valid),
        .out_op    (out_op),
        .out_hash  (out_hash),
        .out_key   (out_key),
        .out_value (out_value),
        .busy      (busy),
        .req_cnt   (req_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    // zlib CRC-32 over the 12 key bytes, most significant byte first, via byte table.
    function automatic logic [31:0] crc32_model(input logic [95:0] key);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < KB; i++) begin
            b = key[95 - 8 * i -: 8];
            c = crc_tbl[c[7:0] ^ b] ^ (c >> 8);
        end
        return ~c;
    endfunction

    task automatic run_req(input logic [3:0] op, input logic [95:0] key, input logic [31:0] val,
                           input bit scramble, input bit keep_valid, input logic [31:0] eh,
                           input string nm, output int acc_cyc);
        int n;
        int bad;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_wait"}, n, (n < 100) ? n : 0);
        s_valid = 1'b1;
        s_op    = op;
        s_key   = key;
        s_value = val;
        @(negedge clk);
        acc_cyc = cyc;
        // Cycles T+1..T+12: hashing, previous outputs must hold.
        bad = 0;
        for (int i = 1; i <= KB; i++) begin
            if (!keep_valid) s_valid = 1'b0;
            if (scramble) begin
                s_key   = {$urandom, $urandom, $urandom};
                s_op    = 4'($urandom);
                s_value = $urandom;
            end
            if (out_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1 || out_key !== p_key ||
                out_op !== p_op || out_value !== p_val || out_hash !== p_hash) bad++;
            @(negedge clk);
        end
        chk({nm, "_hash_phase"}, bad, 0);
        // Cycle T+13: the issue pulse.
        m_cnt = m_cnt + 32'd1;
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_out_hash"}, out_hash, eh);
        chk({nm, "_out_key"}, out_key, key);
        chk({nm, "_out_op"}, out_op, op);
        chk({nm, "_out_value"}, out_value, val);
        chk({nm, "_req_cnt"}, req_cnt, m_cnt);
        p_op   = op;
        p_key  = key;
        p_val  = val;
        p_hash = eh;
        @(negedge clk);
        // Cycles T+14..T+19: hold window.
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1 || out_key !== p_key ||
                out_op !== p_op || out_value !== p_val || out_hash !== p_hash ||
                req_cnt !== m_cnt) bad++;
            @(negedge clk);
        end
        chk({nm, "_hold_phase"}, bad, 0);
        // Cycle T+20: ready again.
        chk({nm, "_ready_back"}, {s_ready, busy, out_valid}, 3'b100);
    endtask

    initial begin
        int a;
        int bad;
        logic [95:0] k;
        logic [31:0] c;

        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tbl[n] = c;
        end

        vecs[0] = '{4'h0, 96'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{4'h3, 96'h3132_3334_3536_3738_3961_6263, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{4'h5, 96'hA5A5_0F0F_FFFF_0000_1234_5678, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{4'h1, 96'h0000_0000_0000_0000_0000_0001, 32'h1111_1111, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{4'h2, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h2222_2222, 1'b0, 1'b1, 32'h0};
        vecs[5] = '{4'h7, 96'h8000_0000_0000_0000_0000_0000, 32'h3333_3333, 1'b0, 1'b0, 32'h0};
        for (int i = 0; i < 6; i++) vecs[i].exp_hash = crc32_model(vecs[i].key);

        rst     = 1'b1;
        s_valid = 1'b0;
        s_op    = '0;
        s_key   = '0;
        s_value = '0;
        p_op    = '0;
        p_key   = '0;
        p_val   = '0;
        p_hash  = '0;
        m_cnt   = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {s_ready, out_valid, busy, out_op, out_value, out_hash, req_cnt}, 0);
        chk("reset_out_key", out_key, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", s_ready, 1);

        // Directed table; the first entry is accepted in the first cycle after release.
        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].op, vecs[i].key, vecs[i].val, vecs[i].scramble, vecs[i].keep_valid,
                    vecs[i].exp_hash, $sformatf("vec%0d", i), acc[i]);
        end
        s_valid = 1'b0;
        chk("b2b_spacing_0", acc[4] - acc[3], 20);
        chk("b2b_spacing_1", acc[5] - acc[4], 20);

        // Reset in cycle T+5 of a request abandons it.
        @(negedge clk);
        s_valid = 1'b1;
        s_op    = 4'h1;
        s_key   = 96'hDEAD_BEEF_CAFE_F00D_0123_4567;
        s_value = 32'h5555_AAAA;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {s_ready, out_valid, busy, out_op, out_value, out_hash, req_cnt}, 0);
        chk("rst_async_out_key", out_key, 0);
        p_op   = '0;
        p_key  = '0;
        p_val  = '0;
        p_hash = '0;
        m_cnt  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_release", s_ready, 1);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || req_cnt !== 32'd0 || busy !== 1'b0) bad++;
        end
        chk("rst_no_issue", bad, 0);
        k = 96'h0102_0304_0506_0708_090A_0B0C;
        run_req(4'h1, k, 32'hFEED_0001, 1'b0, 1'b0, crc32_model(k), "post_rst", a);

        // Counter wrap.
        @(negedge clk);
        force dut.r_req_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_req_cnt;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap_preload", req_cnt, m_cnt);
        k = 96'h6162_6364_6566_6768_696A_6B6C;
        run_req(4'h0, k, 32'h0, 1'b0, 1'b0, crc32_model(k), "wrap", a);

        // Randomized requests with random gaps and input churn during hashing.
        for (int r = 0; r < 8; r++) begin
            logic [3:0]  rop;
            logic [31:0] rval;
            bit          scr;
            rop  = 4'($urandom);
            rval = $urandom;
            k    = {$urandom, $urandom, $urandom};
            scr  = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_req(rop, k, rval, scr, 1'b0, crc32_model(k), $sformatf("rand%0d", r), a);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/db_req_gen.md
# db_req_gen

Request generator directly upstream of the hash-table controller. It accepts one parsed request (op, key, value) at a time from the packet parser over a valid/ready handshake and computes a CRC-32 hash of the key, one byte per cycle. It then issues a single-cycle request pulse with key, op, value and hash held stable, and enforces a hold window so the controller can keep sampling key and op during its multi-cycle lookup/update sequence.

## Interface
- KEY_SIZE, 96: key width in bits; must be a multiple of 8 (KEY_BYTES = KEY_SIZE/8).
- HASH_SIZE, 32: hash width; fixed at 32 (CRC-32).
- VAL_SIZE, 32: value width.
- HOLD_CYCLES, 6: idle cycles after each issue before the next request may be accepted; ≥ 5.
- clk  in  1  system clock (single clock domain).
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream request valid.
- s_ready  out  1  block can accept a request.
- s_op  in  4  op code; bit0 SET(1)/GET(0), bits[2:1] state.
- s_key  in  KEY_SIZE  lookup key.
- s_value  in  VAL_SIZE  value for SET.
- out_valid  out  1  one-cycle request pulse to the controller.
- out_op  out  4  registered op.
- out_hash  out  HASH_SIZE  CRC-32 of out_key.
- out_key  out  KEY_SIZE  registered key.
- out_value  out  VAL_SIZE  registered value.
- busy  out  1  high in any state other than IDLE.
- req_cnt  out  32  count of issued requests; wraps.

## Operation
- States: IDLE, HASH, ISSUE, HOLD.
- IDLE: s_ready=1. On s_valid&&s_ready, capture s_op/s_key/s_value into working registers, set crc=0xFFFFFFFF and byte_idx=0, then go to HASH.
- HASH: each cycle fold byte key[KEY_SIZE-1-8*byte_idx -: 8] into crc using reflected CRC-32 (poly 0xEDB88320, LSB-first within the byte, 8 bit-steps combinationally). Increment byte_idx. After the byte with byte_idx=KEY_BYTES-1, go to ISSUE. Bytes are processed MSB byte first, so the result equals standard CRC-32 (zlib) over the byte string key[95:88]..key[7:0].
- ISSUE, entry edge: load out_key/out_op/out_value from the working registers and load out_hash = crc ^ 0xFFFFFFFF. out_valid=1 for exactly this one cycle. req_cnt increments by 1 (modulo 2^32). Next state: HOLD with hold_cnt=0.
- HOLD: hold_cnt increments each cycle. After HOLD_CYCLES cycles, go to IDLE.
- out_key/out_op/out_value/out_hash change only on ISSUE entry. They stay stable from the out_valid pulse until the next issue.
- s_ready=0 in HASH, ISSUE and HOLD. s_valid is ignored there and upstream must hold it (standard valid/ready; no drop).
- Inputs s_* are sampled only on the accept edge. Later changes do not affect the request in flight.

## Timing
- Accept at rising edge T. HASH occupies cycles T+1..T+KEY_BYTES. out_valid is high in cycle T+KEY_BYTES+1 (T+13 at defaults).
- s_ready returns high in cycle T+KEY_BYTES+2+HOLD_CYCLES (T+20 at defaults). Minimum accept-to-accept spacing is KEY_BYTES+2+HOLD_CYCLES (20) cycles.
- s_ready is a registered state decode, not combinational from s_valid.
- Reset (async assert, any state): state=IDLE, s_ready=0 while rst is high and 1 in the first cycle after release. out_valid=0, out_op/out_hash/out_key/out_value=0, busy=0, req_cnt=0, all working registers 0.
- Reset mid-HASH/ISSUE/HOLD abandons the request. No out_valid follows; req_cnt is not incremented for it.
- s_valid high in the first cycle after reset release is accepted in that cycle.
- req_cnt wraps 0xFFFFFFFF→0 without a flag.

## Test plan
- Single GET: s_op=4'h0, s_key=96'h0, held one accept → out_valid exactly one cycle at T+13. out_hash = zlib.crc32(12 zero bytes) per the bench model; out_op=0; req_cnt=1.
- SET with data: s_op=4'h3, s_key=96'h3132_3334_3536_3738_3961_6263 ("123456789abc"), s_value=32'hDEAD_BEEF → out_hash = zlib.crc32(b"123456789abc"), out_value=32'hDEADBEEF, out_key/op/value/hash unchanged through all 6 HOLD cycles and beyond.
- Back-to-back: s_valid held high with 3 different keys → accepts spaced exactly 20 cycles apart. Each out_valid carries the matching hash. s_ready never high in HASH/ISSUE/HOLD.
- Input change after accept: change s_key every cycle during HASH → out_key/out_hash reflect the value captured at accept.
- Reset mid-HASH: assert rst at T+5 → all outputs 0 immediately (asynchronous). No out_valid after release. req_cnt=0. A new request after release completes normally.
- Counter wrap: force req_cnt to 0xFFFFFFFF, issue one request → req_cnt=0, out_valid still pulses once.
